sopc_data_mem: RTL and testbench
================================

// Module: sopc_data_mem
// PURPOSE
//  Parametrised data memory for the SOPC top that replaces the single-cycle data RAM.
//  It adds a configurable wait-state FSM with a ready/busy handshake, so that the
//  MEM stage can stall on slow memory.
//  It also decodes a base address and flags out-of-range accesses with an error pulse.
//  It sits between the CPU's ram_* port and the array storage.
// PARAMETERS
//  DATA_W       32         data width in bits; a multiple of 8
//  ADDR_W       32         byte address width
//  DEPTH_WORDS  1024       number of DATA_W words of storage
//  WAIT_STATES  1          extra cycles per access, range 0..15
//  BASE_ADDR    32'h0      byte address of word 0
// PORTS
//  clk      in   1         clock; all logic on the rising edge
//  rst      in   1         synchronous reset, active-low (0 = reset)
//  ce       in   1         access request; sampled only in IDLE
//  we       in   1         1 = write, 0 = read
//  addr     in   ADDR_W    byte address; low log2(DATA_W/8) bits ignored
//  sel      in   DATA_W/8  byte-lane write enables; bit i drives data_i[8i+7:8i]
//  data_i   in   DATA_W    write data
//  data_o   out  DATA_W    read data; valid while ready=1
//  ready    out  1         one-cycle completion pulse
//  err      out  1         out-of-range flag; valid with ready
//  busy     out  1         access in flight; the CPU uses it as stall request
// BEHAVIOUR
//  Reset (rst=0 at an edge):
//   - state=IDLE, cnt=0; data_o, ready, err and busy all 0.
//   - Any in-flight access is dropped: no write occurs.
//   - Memory contents are not cleared.
//  Word index:
//   - idx = (addr - BASE_ADDR) >> log2(DATA_W/8).
//   - The access is in range when addr >= BASE_ADDR and idx < DEPTH_WORDS.
//  FSM states: IDLE, WAIT.
//   - IDLE, ce=1: latch we, idx, sel, data_i and the range flag; cnt<=0; busy<=1;
//     go to WAIT.
//   - IDLE, ce=0: no change.
//   - WAIT, cnt<WAIT_STATES: cnt<=cnt+1.
//   - WAIT, cnt==WAIT_STATES: perform the access; ready<=1; busy<=0; go to IDLE.
//  Latency: ready is high in the cycle after edge (accept+WAIT_STATES+1).
//   Example: accept at edge E0, WAIT_STATES=0 -> ready is high after edge E1.
//  ready and err are single-cycle pulses, cleared at the next edge.
//  data_o holds its value until the next completion.
//  Completed writes:
//   - Only lanes with sel[i]=1 are updated.
//   - sel=0 still completes with ready, but changes nothing.
//   - data_o<=0.
//  Completed reads: data_o<=mem[idx], the full word regardless of sel.
//   The CPU performs byte/half extraction.
//  Out of range:
//   - No write; data_o<=0; err<=1 together with ready.
//  ce while busy=1, including the completion cycle: ignored, not queued.
//   The requester holds ce and the request is accepted on the first IDLE edge.
//   Back-to-back maximum rate is therefore one access per WAIT_STATES+2 cycles.
//  Inputs are captured at acceptance; changes to addr, data_i or sel during WAIT
//   have no effect.
// TESTING
//  1. Default params: write 0xDEADBEEF to 0x10 with sel=4'hF, then read 0x10
//     -> ready 2 cycles after each accept; data_o=0xDEADBEEF, err=0.
//  2. Byte lanes: mem[0x20]=0x11223344; write 0xAABBCCDD with sel=4'b0101;
//     read -> 0x11BB33DD.
//  3. WAIT_STATES=0 and WAIT_STATES=3: with ce held high, ready spacing is 2 and 5
//     cycles; busy is high exactly between accept and ready.
//  4. BASE_ADDR=0x1000, DEPTH_WORDS=16: read 0x0FFC and 0x1040 -> err=1, data_o=0;
//     read 0x103C -> err=0.
//  5. Assert rst=0 mid-WAIT of a write to 0x8, then read 0x8 -> old value retained;
//     ready, busy and err are 0 during reset.
//  6. Change addr and data_i during WAIT -> the originally latched address and data
//     are written.

Source files
------------

// File: rtl/sopc_data_mem.sv
// rtl/sopc_data_mem.sv - data memory with wait-state FSM, ready/busy handshake and range error
module sopc_data_mem #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter int                WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   sel,
  input  logic [DATA_W-1:0]     data_i,
  output logic [DATA_W-1:0]     data_o,
  output logic                  ready,
  output logic                  err,
  output logic                  busy
);

  localparam int              LANES     = DATA_W / 8;
  localparam int              LSB       = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int              IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH_WORDS);
  localparam logic [3:0]      WS        = 4'(WAIT_STATES);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LANES-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                inr_q, inr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                mem_we;

  logic [DATA_W-1:0]   mem [DEPTH_WORDS];

  logic [ADDR_W-1:0]   off;
  logic [ADDR_W-1:0]   word_off;
  logic                in_range;

  // Addresses below the base wrap to huge offsets, so both bounds are checked explicitly.
  assign off      = addr - BASE_ADDR;
  assign word_off = off >> LSB;
  assign in_range = (addr >= BASE_ADDR) && ({1'b0, word_off} < DEPTH_LIM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    inr_d   = inr_q;
    data_d  = data_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ce) begin
          we_d    = we;
          idx_d   = word_off[IDX_W-1:0];
          sel_d   = sel;
          wdata_d = data_i;
          inr_d   = in_range;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != WS) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
          if (!inr_q) begin
            err_d  = 1'b1;
            data_d = '0;
          end else if (we_q) begin
            mem_we = 1'b1;
            data_d = '0;
          end else begin
            data_d = mem[idx_q];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      inr_q   <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      inr_q   <= inr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Storage is never cleared; reset only suppresses a completing write.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (sel_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign data_o = data_q;
  assign ready  = ready_q;
  assign err    = err_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_sopc_data_mem.sv
// tb/tb_sopc_data_mem.sv - directed bench for sopc_data_mem over three parameter sets
module tb_sopc_data_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] dout0, dout1, dout2;
  logic [2:0]  rdy, errv, bsy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sopc_data_mem u_dut0 (
    .clk(clk), .rst(rst), .ce(ce[0]), .we(we), .addr(addr), .sel(sel), .data_i(data_i),
    .data_o(dout0), .ready(rdy[0]), .err(errv[0]), .busy(bsy[0])
  );

  sopc_data_mem #(.WAIT_STATES(0)) u_dut1 (
    .clk(clk), .rst(rst), .ce(ce[1]), .we(we), .addr(addr), .sel(sel), .data_i(data_i),
    .data_o(dout1), .ready(rdy[1]), .err(errv[1]), .busy(bsy[1])
  );

  sopc_data_mem #(.WAIT_STATES(3), .BASE_ADDR(32'h1000), .DEPTH_WORDS(16)) u_dut2 (
    .clk(clk), .rst(rst), .ce(ce[2]), .we(we), .addr(addr), .sel(sel), .data_i(data_i),
    .data_o(dout2), .ready(rdy[2]), .err(errv[2]), .busy(bsy[2])
  );

  function automatic logic [31:0] get_dout(input int d);
    case (d)
      0:       return dout0;
      1:       return dout1;
      default: return dout2;
    endcase
  endfunction

  // One access; inputs are scrambled right after acceptance to prove they were captured.
  task automatic access(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    @(negedge clk);
    we = w; addr = a; sel = s; data_i = wd; ce[d] = 1'b1;
    @(posedge clk);
    #1;
    ce[d] = 1'b0; we = ~w; addr = a ^ 32'h4; sel = ~s; data_i = ~wd;
    lat = 0; rd = 'x; er = 1'bx;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rdy[d] === 1'b1) begin
        rd = get_dout(d);
        er = errv[d];
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ce = '0; we = 0; addr = 0; sel = 0; data_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({rdy[d], errv[d], bsy[d]} !== 3'b000 || get_dout(d) !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: ready=%b err=%b busy=%b data_o=%h, required all 0",
                 d, rdy[d], errv[d], bsy[d], get_dout(d));
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int lat;
    access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL basic_write: lat=%0d err=%b data_o=%h, required lat=2 err=0 data_o=0", lat, er, rd);
    end
    access(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_read: lat=%0d err=%b data_o=%h, required lat=2 err=0 data_o=deadbeef", lat, er, rd);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat;
    access(0, 1'b1, 32'h20, 4'hF, 32'h11223344, rd, er, lat);
    access(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, rd, er, lat);
    access(0, 1'b0, 32'h20, 4'hF, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_lanes: data_o=%h, required 11bb33dd", rd);
    end
    access(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, rd, er, lat);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sel0_write: lat=%0d err=%b data_o=%h, required lat=2 err=0 data_o=0", lat, er, rd);
    end
    access(0, 1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL sel0_readback: data_o=%h, required 11bb33dd", rd);
    end
  endtask

  task automatic test_range();
    logic [31:0] rd; logic er; int lat;
    access(2, 1'b1, 32'h103C, 4'hF, 32'hCAFEF00D, rd, er, lat);
    access(2, 1'b1, 32'h1000, 4'hF, 32'h12345678, rd, er, lat);
    checks++;
    if (lat !== 4 || er !== 1'b0) begin
      errors++;
      $display("FAIL ws3_latency: lat=%0d err=%b, required lat=4 err=0", lat, er);
    end
    access(2, 1'b1, 32'h1040, 4'hF, 32'hFFFFFFFF, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL oor_write: err=%b data_o=%h, required err=1 data_o=0", er, rd);
    end
    access(2, 1'b0, 32'h0FFC, 4'hF, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL oor_below: err=%b data_o=%h, required err=1 data_o=0", er, rd);
    end
    access(2, 1'b0, 32'h1040, 4'hF, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL oor_above: err=%b data_o=%h, required err=1 data_o=0", er, rd);
    end
    access(2, 1'b0, 32'h103C, 4'hF, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL last_word: err=%b data_o=%h, required err=0 data_o=cafef00d", er, rd);
    end
    access(2, 1'b0, 32'h1000, 4'hF, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h12345678) begin
      errors++;
      $display("FAIL oor_no_write: err=%b data_o=%h, required err=0 data_o=12345678", er, rd);
    end
  endtask

  task automatic test_back_to_back(input int d, input int ws, input logic [31:0] a);
    int cyc, last, pulses, bad;
    cyc = 0; last = -1; pulses = 0; bad = 0;
    @(negedge clk);
    we = 1'b0; addr = a; sel = 4'hF; ce[d] = 1'b1;
    repeat (3 * (ws + 2) + 2) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bsy[d] !== ~rdy[d]) bad++;
      if (rdy[d] === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last !== ws + 2) begin
            errors++;
            $display("FAIL b2b_spacing ws=%0d: spacing=%0d, required %0d", ws, cyc - last, ws + 2);
          end
        end
        last = cyc;
        pulses++;
      end
    end
    checks++;
    if (pulses < 3 || bad != 0) begin
      errors++;
      $display("FAIL b2b_busy ws=%0d: pulses=%0d busy_errors=%0d, required pulses>=3 busy_errors=0",
               ws, pulses, bad);
    end
    ce[d] = 1'b0;
    for (int i = 0; i < 20 && bsy[d] !== 1'b0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int lat;
    access(0, 1'b1, 32'h8, 4'hF, 32'h01020304, rd, er, lat);
    access(0, 1'b0, 32'h8, 4'hF, 32'h0, rd, er, lat);
    @(negedge clk);
    we = 1'b1; addr = 32'h8; sel = 4'hF; data_i = 32'hFFFFFFFF; ce[0] = 1'b1;
    @(posedge clk);
    #1 ce[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (bsy[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_wait_busy: busy=%b, required 1", bsy[0]);
    end
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rdy[0], bsy[0], errv[0]} !== 3'b000 || dout0 !== 32'h0) begin
        errors++;
        $display("FAIL reset_mid_wait: ready=%b busy=%b err=%b data_o=%h, required all 0",
                 rdy[0], bsy[0], errv[0], dout0);
      end
    end
    rst = 1'b1;
    access(0, 1'b0, 32'h8, 4'hF, 32'h0, rd, er, lat);
    checks++;
    if (lat !== 2 || rd !== 32'h01020304) begin
      errors++;
      $display("FAIL reset_retained: lat=%0d data_o=%h, required lat=2 data_o=01020304", lat, rd);
    end
  endtask

  task automatic test_capture();
    logic [31:0] rd; logic er; int lat;
    access(0, 1'b1, 32'h34, 4'hF, 32'h00000000, rd, er, lat);
    access(0, 1'b1, 32'h30, 4'hF, 32'hA5A5A5A5, rd, er, lat);
    access(0, 1'b0, 32'h34, 4'hF, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL capture_other_addr: data_o=%h, required 0", rd);
    end
    access(0, 1'b0, 32'h30, 4'h0, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL capture_latched: data_o=%h, required a5a5a5a5", rd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_range();
    test_back_to_back(1, 0, 32'h0);
    test_back_to_back(2, 3, 32'h1000);
    test_reset_mid_wait();
    test_capture();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
